// File: rtl/bridge_lift_sequencer_if.sv
// Deck-side signal bundle of the bridge lift sequencer: sensor/motor inputs and lamp/barrier/motor outputs.
// The sequencer attaches through the slave modport; the environment driving it uses master.
interface bridge_lift_sequencer_if;
    logic       i_car_in;
    logic       i_car_out;
    logic       i_boat_req;
    logic       i_boat_clear;
    logic       i_motor_done;
    logic       o_barrier;
    logic       o_alert;
    logic       o_motor_up;
    logic       o_motor_down;
    logic       o_fault;
    logic [3:0] o_car_count;
    logic [2:0] o_state;

    modport master (
        output i_car_in, i_car_out, i_boat_req, i_boat_clear, i_motor_done,
        input  o_barrier, o_alert, o_motor_up, o_motor_down, o_fault, o_car_count, o_state
    );

    modport slave (
        input  i_car_in, i_car_out, i_boat_req, i_boat_clear, i_motor_done,
        output o_barrier, o_alert, o_motor_up, o_motor_down, o_fault, o_car_count, o_state
    );
endinterface

// File: rtl/bridge_lift_sequencer.sv
// Bascule bridge lift sequencer: road-open guard, warning, deck drain, raise/hold/lower and car counting.
// Optional motor watchdog with latched fault is enabled by defining BRIDGE_MOTOR_TIMEOUT_EN.
module bridge_lift_sequencer #(
    parameter int WARN_CYCLES     = 8,
    parameter int MIN_OPEN_CYCLES = 16,
    parameter int MOTOR_TIMEOUT   = 64
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    bridge_lift_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_ROAD  = 3'b000,
        ST_WARN  = 3'b001,
        ST_DRAIN = 3'b010,
        ST_RAISE = 3'b011,
        ST_UP    = 3'b100,
        ST_LOWER = 3'b101,
        ST_FAULT = 3'b110
    } state_e;

    // One shared timer serves the open guard, the warning period and the motor watchdog.
    localparam int TMR_MAX_A = (MIN_OPEN_CYCLES > WARN_CYCLES) ? MIN_OPEN_CYCLES : WARN_CYCLES;
    localparam int TMR_MAX   = (TMR_MAX_A > MOTOR_TIMEOUT) ? TMR_MAX_A : MOTOR_TIMEOUT;
    localparam int TW        = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] OPEN_MAX  = TW'(MIN_OPEN_CYCLES);
    localparam logic [TW-1:0] WARN_LAST = TW'(WARN_CYCLES - 1);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
`ifdef BRIDGE_MOTOR_TIMEOUT_EN
    localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_TIMEOUT - 1);
`endif

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    count_q, count_d;
    logic          barrier_q, alert_q, up_q, down_q, fault_q;
    logic          barrier_d, alert_d, up_d, down_d, fault_d;
    logic          inc_s, dec_s;

    // Car counter next value: entries only while the road is open or warning, exits until fault.
    always_comb begin
        inc_s   = bus.i_car_in && ((state_q == ST_ROAD) || (state_q == ST_WARN));
        dec_s   = bus.i_car_out && (state_q != ST_FAULT);
        count_d = count_q;
        if (inc_s && !dec_s) begin
            if (count_q != 4'd15) begin
                count_d = count_q + 4'd1;
            end else begin
                count_d = count_q;
            end
        end else if (dec_s && !inc_s) begin
            if (count_q != 4'd0) begin
                count_d = count_q - 4'd1;
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Sequencer next state and timer.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_ROAD: begin
                if (bus.i_boat_req && (tmr_q >= OPEN_MAX)) begin
                    state_d = ST_WARN;
                    tmr_d   = '0;
                end else if (tmr_q < OPEN_MAX) begin
                    tmr_d = tmr_q + TMR_ONE;
                end else begin
                    tmr_d = tmr_q;
                end
            end
            ST_WARN: begin
                if (!bus.i_boat_req) begin
                    state_d = ST_ROAD;
                    tmr_d   = '0;
                end else if (tmr_q >= WARN_LAST) begin
                    state_d = ST_DRAIN;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_DRAIN: begin
                if (!bus.i_boat_req) begin
                    state_d = ST_ROAD;
                    tmr_d   = '0;
                end else if (count_q == 4'd0) begin
                    state_d = ST_RAISE;
                    tmr_d   = '0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RAISE: begin
                if (bus.i_motor_done) begin
                    state_d = ST_UP;
                    tmr_d   = '0;
`ifdef BRIDGE_MOTOR_TIMEOUT_EN
                end else if (tmr_q >= MOTOR_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
`else
                end else begin
                    state_d = ST_RAISE;
                end
`endif
            end
            ST_UP: begin
                if (bus.i_boat_clear) begin
                    state_d = ST_LOWER;
                    tmr_d   = '0;
                end else begin
                    state_d = ST_UP;
                end
            end
            ST_LOWER: begin
                // Boat requests are not looked at here, so the descent is never reversed.
                if (bus.i_motor_done) begin
                    state_d = ST_ROAD;
                    tmr_d   = '0;
`ifdef BRIDGE_MOTOR_TIMEOUT_EN
                end else if (tmr_q >= MOTOR_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
`else
                end else begin
                    state_d = ST_LOWER;
                end
`endif
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_DRAIN;
                tmr_d   = '0;
            end
        endcase
    end

    // Output decode of the upcoming state so the registered outputs track o_state exactly.
    always_comb begin
        barrier_d = 1'b1;
        alert_d   = 1'b1;
        up_d      = 1'b0;
        down_d    = 1'b0;
        case (state_d)
            ST_ROAD: begin
                barrier_d = 1'b0;
                alert_d   = 1'b0;
            end
            ST_WARN:  barrier_d = 1'b0;
            ST_RAISE: up_d      = 1'b1;
            ST_LOWER: down_d    = 1'b1;
            default: begin
                barrier_d = 1'b1;
                alert_d   = 1'b1;
            end
        endcase
`ifdef BRIDGE_MOTOR_TIMEOUT_EN
        fault_d = (state_d == ST_FAULT);
`else
        fault_d = 1'b0;
`endif
    end

    // State, timer, counter and output registers; reset drops the motor commands asynchronously.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_ROAD;
            tmr_q     <= '0;
            count_q   <= 4'd0;
            barrier_q <= 1'b0;
            alert_q   <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            count_q   <= count_d;
            barrier_q <= barrier_d;
            alert_q   <= alert_d;
            up_q      <= up_d;
            down_q    <= down_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.o_state      = state_q;
    assign bus.o_car_count  = count_q;
    assign bus.o_barrier    = barrier_q;
    assign bus.o_alert      = alert_q;
    assign bus.o_motor_up   = up_q;
    assign bus.o_motor_down = down_q;
    assign bus.o_fault      = fault_q;

endmodule

// File: tb/tb_bridge_lift_sequencer.sv
// Bench for bridge_lift_sequencer: directed lift scenarios plus randomized traffic against a reference model.
// Honours BRIDGE_MOTOR_TIMEOUT_EN when the whole bundle is built with it.
module tb_bridge_lift_sequencer;

    localparam int WARN_N    = 8;
    localparam int OPEN_N    = 16;
    localparam int TIMEOUT_N = 64;
`ifdef BRIDGE_MOTOR_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int S_ROAD = 0, S_WARN = 1, S_DRAIN = 2, S_RAISE = 3, S_UP = 4, S_LOWER = 5, S_FAULT = 6;

    typedef struct {
        int st;
        int cars;
        int road_cycles;
        int warn_cycles;
        int motor_cycles;
    } model_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    bit   chk_en;
    model_t mdl;

    bridge_lift_sequencer_if bus ();

    bridge_lift_sequencer #(
        .WARN_CYCLES    (WARN_N),
        .MIN_OPEN_CYCLES(OPEN_N),
        .MOTOR_TIMEOUT  (TIMEOUT_N)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of the bridge rules, worked out from cycle counts rather than a state register.
    function automatic model_t model_step(model_t m, bit car_in, bit car_out, bit boat_req,
                                          bit boat_clear, bit motor_done);
        model_t n      = m;
        bit     in_ok  = car_in && (m.st == S_ROAD || m.st == S_WARN);
        bit     out_ok = car_out && (m.st != S_FAULT);
        if (in_ok && !out_ok)      n.cars = (m.cars < 15) ? m.cars + 1 : 15;
        else if (out_ok && !in_ok) n.cars = (m.cars > 0) ? m.cars - 1 : 0;
        case (m.st)
            S_ROAD:
                if (boat_req && m.road_cycles >= OPEN_N) begin n.st = S_WARN; n.warn_cycles = 0; end
                else n.road_cycles = (m.road_cycles < OPEN_N) ? m.road_cycles + 1 : OPEN_N;
            S_WARN:
                if (!boat_req) begin n.st = S_ROAD; n.road_cycles = 0; end
                else begin
                    n.warn_cycles = m.warn_cycles + 1;
                    if (n.warn_cycles == WARN_N) n.st = S_DRAIN;
                end
            S_DRAIN:
                if (!boat_req) begin n.st = S_ROAD; n.road_cycles = 0; end
                else if (m.cars == 0) begin n.st = S_RAISE; n.motor_cycles = 0; end
            S_RAISE, S_LOWER:
                if (motor_done) begin
                    n.st = (m.st == S_RAISE) ? S_UP : S_ROAD;
                    n.road_cycles = 0;
                end else if (TIMEOUT_ON) begin
                    n.motor_cycles = m.motor_cycles + 1;
                    if (n.motor_cycles >= TIMEOUT_N) n.st = S_FAULT;
                end
            S_UP:
                if (boat_clear) begin n.st = S_LOWER; n.motor_cycles = 0; end
            default: ;
        endcase
        return n;
    endfunction

    // Reference model state, updated on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mdl <= '{S_ROAD, 0, 0, 0, 0};
        else        mdl <= model_step(mdl, bus.i_car_in, bus.i_car_out, bus.i_boat_req,
                                      bus.i_boat_clear, bus.i_motor_done);
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check_val("state",   32'(bus.o_state),      32'(mdl.st));
            check_val("count",   32'(bus.o_car_count),  32'(mdl.cars));
            check_val("barrier", 32'(bus.o_barrier),    32'(mdl.st >= S_DRAIN));
            check_val("alert",   32'(bus.o_alert),      32'(mdl.st != S_ROAD));
            check_val("up",      32'(bus.o_motor_up),   32'(mdl.st == S_RAISE));
            check_val("down",    32'(bus.o_motor_down), 32'(mdl.st == S_LOWER));
            check_val("fault",   32'(bus.o_fault),      32'(mdl.st == S_FAULT));
            check_val("excl",    32'(bus.o_motor_up & bus.o_motor_down), 32'd0);
        end
    end

    task automatic drive_idle();
        bus.i_car_in     = 1'b0;
        bus.i_car_out    = 1'b0;
        bus.i_boat_req   = 1'b0;
        bus.i_boat_clear = 1'b0;
        bus.i_motor_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        check_val("rst_state",   32'(bus.o_state),     32'd0);
        check_val("rst_count",   32'(bus.o_car_count), 32'd0);
        check_val("rst_outputs", 32'({bus.o_barrier, bus.o_alert, bus.o_motor_up,
                                      bus.o_motor_down, bus.o_fault}), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input bit cin, input bit cout, input bit clr, input bit done);
        bus.i_car_in     = cin;
        bus.i_car_out    = cout;
        bus.i_boat_clear = clr;
        bus.i_motor_done = done;
        @(negedge clk);
        bus.i_car_in     = 1'b0;
        bus.i_car_out    = 1'b0;
        bus.i_boat_clear = 1'b0;
        bus.i_motor_done = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, output int cycles);
        cycles = 0;
        while (32'(bus.o_state) != target && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_val("wait_state", 32'(bus.o_state), 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_seq[6];
        exp_seq  = '{1, 2, 3, 2, 1, 0};
        n_checks = 0;
        n_fails  = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        do_reset();

        // Cars only, then count boundaries.
        for (int i = 0; i < 6; i++) begin
            pulse(i < 3, i >= 3, 1'b0, 1'b0);
            check_val("cars_seq", 32'(bus.o_car_count), 32'(exp_seq[i]));
            check_val("cars_state", 32'({bus.o_state, bus.o_barrier}), 32'd0);
        end
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("hold_zero", 32'(bus.o_car_count), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check_val("in_out_same", 32'(bus.o_car_count), 32'd1);
        for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("sat_15", 32'(bus.o_car_count), 32'd15);

        // Full lift with an empty deck.
        do_reset();
        idle(OPEN_N);
        bus.i_boat_req = 1'b1;
        @(negedge clk);
        for (int i = 0; i < WARN_N; i++) begin
            check_val("lift_warn", 32'(bus.o_state), 32'd1);
            check_val("lift_warn_bar", 32'({bus.o_alert, bus.o_barrier}), 32'd2);
            @(negedge clk);
        end
        check_val("lift_drain", 32'(bus.o_state), 32'd2);
        @(negedge clk);
        check_val("lift_raise", 32'(bus.o_state), 32'd3);
        check_val("lift_up_cmd", 32'(bus.o_motor_up), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lift_up", 32'(bus.o_state), 32'd4);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("lift_lower", 32'(bus.o_state), 32'd5);
        check_val("lift_down_cmd", 32'(bus.o_motor_down), 32'd1);
        idle(3);
        check_val("no_reverse", 32'({bus.o_motor_up, bus.o_motor_down}), 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("lift_road", 32'(bus.o_state), 32'd0);
        check_val("lift_road_bar", 32'(bus.o_barrier), 32'd0);
        bus.i_boat_req = 1'b0;

        // Drain holds the lift until the deck is empty.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        idle(OPEN_N);
        bus.i_boat_req = 1'b1;
        wait_state(S_DRAIN, 40, n);
        idle(3);
        check_val("drain_hold", 32'(bus.o_state), 32'd2);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("drain_in_ignored", 32'(bus.o_car_count), 32'd2);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("drain_out1", 32'(bus.o_car_count), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("drain_out2", 32'({bus.o_state, bus.o_car_count}), 32'({3'd2, 4'd0}));
        @(negedge clk);
        check_val("drain_raise", 32'(bus.o_state), 32'd3);

        // Open-time guard and warning abort.
        do_reset();
        idle(5);
        bus.i_boat_req = 1'b1;
        n = 5;
        while (bus.o_state != 3'b001 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("guard_cycles", 32'(n), 32'd17);
        idle(3);
        bus.i_boat_req = 1'b0;
        @(negedge clk);
        check_val("abort_road", 32'({bus.o_state, bus.o_alert}), 32'd0);
        bus.i_boat_req = 1'b1;
        n = 0;
        while (bus.o_state != 3'b001 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_val("guard_restart", 32'(n), 32'd17);

        // Stalled motor, then reset in the middle of a lift.
        do_reset();
        idle(OPEN_N);
        bus.i_boat_req = 1'b1;
        wait_state(S_RAISE, 40, n);
        idle(TIMEOUT_N);
        check_val("timeout_state", 32'(bus.o_state), TIMEOUT_ON ? 32'd6 : 32'd3);
        check_val("timeout_fault", 32'(bus.o_fault), TIMEOUT_ON ? 32'd1 : 32'd0);
        check_val("timeout_up", 32'(bus.o_motor_up), TIMEOUT_ON ? 32'd0 : 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_state", 32'(bus.o_state), 32'd0);
        check_val("async_motor", 32'({bus.o_motor_up, bus.o_motor_down, bus.o_fault}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_boat_req = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            rst_n            = ($urandom_range(0, 499) != 0);
            bus.i_car_in     = ($urandom_range(0, 3) == 0);
            bus.i_car_out    = ($urandom_range(0, 3) == 0);
            bus.i_boat_clear = ($urandom_range(0, 9) == 0);
            bus.i_motor_done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 24) == 0) bus.i_boat_req = ~bus.i_boat_req;
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/bridge_lift_sequencer.md
BRIDGE_LIFT_SEQUENCER -- requirements
Module: bridge_lift_sequencer

Interface
REQ-001 SHALL have parameter WARN_CYCLES, default 8, alert-only cycles before barrier closes.
REQ-002 SHALL have parameter MIN_OPEN_CYCLES, default 16, minimum road-open cycles before a lift may start.
REQ-003 SHALL have parameter MOTOR_TIMEOUT, default 64, cycles allowed for a motor move (REQ-025 only).
REQ-004 SHALL have port i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_car_in  in  1  one-cycle pulse per car entering the deck.
REQ-007 SHALL have port i_car_out  in  1  one-cycle pulse per car leaving the deck.
REQ-008 SHALL have port i_boat_req  in  1  level, boat waiting to pass.
REQ-009 SHALL have port i_boat_clear  in  1  one-cycle pulse, boat has passed.
REQ-010 SHALL have port i_motor_done  in  1  motor reached the commanded end position.
REQ-011 SHALL have ports o_barrier, o_alert, o_motor_up, o_motor_down, o_fault  out  1 each  barrier closed, alert lamp, raise command, lower command, fault flag.
REQ-012 SHALL have port o_car_count  out  4  cars on deck.
REQ-013 SHALL have port o_state  out  3  current state encoding.

Function
REQ-014 SHALL implement states ROAD=000, WARN=001, DRAIN=010, RAISE=011, UP=100, LOWER=101, FAULT=110; all outputs registered; a state change occurs on the edge after its condition is sampled.
REQ-015 ROAD: barrier 0, alert 0, motors 0; open timer counts up, saturating at MIN_OPEN_CYCLES, and is cleared on ROAD entry; go to WARN when i_boat_req=1 and the timer has reached MIN_OPEN_CYCLES.
REQ-016 WARN: alert 1, barrier 0; after exactly WARN_CYCLES cycles in WARN, go to DRAIN; if i_boat_req falls during WARN, return to ROAD.
REQ-017 DRAIN: barrier 1, alert 1; go to RAISE when o_car_count=0; if i_boat_req falls, return to ROAD.
REQ-018 RAISE: barrier 1, alert 1, o_motor_up 1; go to UP on i_motor_done=1.
REQ-019 UP: barrier 1, alert 1, motors 0; go to LOWER on i_boat_clear=1; i_boat_req is ignored.
REQ-020 LOWER: barrier 1, alert 1, o_motor_down 1; go to ROAD on i_motor_done=1; a new i_boat_req SHALL NOT reverse the motor.
REQ-021 Car counter: +1 on i_car_in only in ROAD/WARN; -1 on i_car_out in any state except FAULT; simultaneous in and out leave the count unchanged; saturate at 15, hold at 0.
REQ-022 o_motor_up and o_motor_down SHALL never be 1 in the same cycle.
REQ-023 Unused encoding 111 SHALL recover to DRAIN with barrier 1.

Reset
REQ-024 While i_reset_n=0: state ROAD, open timer 0, count 0, all 1-bit outputs 0, o_state 000; reset mid-lift forces ROAD immediately and the motor command drops asynchronously.

Configuration
REQ-025 With macro BRIDGE_MOTOR_TIMEOUT_EN defined, a cycle counter SHALL run in RAISE/LOWER, clear on entry; at MOTOR_TIMEOUT cycles without i_motor_done, go to FAULT: motors 0, barrier 1, alert 1, o_fault 1, counter frozen, exit only by reset. Without the macro, RAISE/LOWER wait indefinitely, FAULT is unreachable and o_fault is constant 0.

Verification
REQ-026 Cars only: 3 i_car_in pulses then 3 i_car_out pulses, no boat -> o_car_count 1,2,3,2,1,0, state stays 000, barrier 0.
REQ-027 Full lift: after 16 ROAD cycles, i_boat_req=1 with 0 cars -> WARN for 8 cycles, DRAIN, RAISE (motor_up=1); motor_done -> UP; boat_clear -> LOWER; motor_done -> ROAD, barrier 0.
REQ-028 Drain: 2 cars on deck, boat_req -> held in DRAIN, i_car_in ignored, count stays 2 until 2 i_car_out pulses, then RAISE the next cycle.
REQ-029 Guard and abort: boat_req 5 cycles after reset -> WARN only after cycle 16; drop boat_req mid-WARN -> ROAD, alert 0, timer restarts.
REQ-030 Timeout (macro on): RAISE with no motor_done for 64 cycles -> o_state 110, o_fault 1, motors 0; i_reset_n low -> 000. With the macro off, the same stimulus leaves the block in RAISE.
